mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage controller for a pipelined core talking to a handshaked data
// memory. A load or store in EX/MEM with a word-aligned address launches one
// memory request and stalls the front of the pipeline until the memory acks
// or a wait counter expires. Misaligned accesses never reach the memory; they
// retire as a bubble with an alignment-error pulse. The block also produces
// the PC redirect for branches and jumps, suppressed while stalled.
//
// Ports
//   clock, reset              : clock; synchronous active-low reset
//   iMemRead .. iZero         : EX/MEM control bits and ALU zero flag
//   iResult                   : ALU result, used as the byte address
//   iB                        : store data
//   inextPCBranch             : branch / jump target
//   iwriteRegWire             : destination register
//   mem_req/we/addr/wdata     : request to the data memory
//   mem_ack, mem_rdata        : completion pulse and read data from memory
//   stall                     : hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   oPCSrc, oPCTarget         : PC redirect and target (combinational)
//   oRegWrite .. owriteRegWire: registered MEM/WB outputs
//   oAlignErr, oTimeout       : registered one-cycle error pulses
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15   // max ACCESS cycles, 1..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iMemToReg,
    input  logic        iRegWrite,
    input  logic        iBranch,
    input  logic        iJump,
    input  logic        iZero,
    input  logic [31:0] iResult,
    input  logic [31:0] iB,
    input  logic [31:0] inextPCBranch,
    input  logic [4:0]  iwriteRegWire,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        oPCSrc,
    output logic [31:0] oPCTarget,
    output logic        oRegWrite,
    output logic        oMemToReg,
    output logic [31:0] oReadData,
    output logic [31:0] oResult,
    output logic [4:0]  owriteRegWire,
    output logic        oAlignErr,
    output logic        oTimeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Last counter value before the wait gives up.
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic        w_mem_op;
    logic        w_aligned;
    logic        w_start;
    logic        w_misalign;
    logic        w_timeout_hit;
    logic        w_stall;
    logic        w_mem_req;

    logic [7:0]  r_wait_cnt;
    logic [31:0] r_rd_buf;
    logic        r_timed_out;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        r_reg_write;
    logic        r_mem_to_reg;
    logic [31:0] r_read_data;
    logic [31:0] r_result;
    logic [4:0]  r_write_reg;
    logic        r_align_err;
    logic        r_timeout;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign w_mem_op   = iMemRead | iMemWrite;
    assign w_aligned  = (iResult[1:0] == 2'b00);
    assign w_start    = (r_state == S_IDLE) & w_mem_op & w_aligned;
    assign w_misalign = (r_state == S_IDLE) & w_mem_op & ~w_aligned;

    // An ack in the last allowed cycle still counts as success.
    assign w_timeout_hit = (r_state == S_ACCESS) & ~mem_ack &
                           (r_wait_cnt == C_WAIT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers sample their inputs from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: assigning a default before the case guarantees every path
    // drives w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack || w_timeout_hit) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Stall is forced low while reset is held so the pipeline is never
    // frozen by a controller that is itself being cleared.
    always_comb begin
        w_stall   = 1'b0;
        w_mem_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_start & reset;
            end
            S_ACCESS: begin
                w_stall   = reset;
                w_mem_req = 1'b1;
            end
            default: begin
                w_stall   = 1'b0;
                w_mem_req = 1'b0;
            end
        endcase
    end

    assign stall     = w_stall;
    assign mem_req   = w_mem_req;
    assign oPCSrc    = ((iBranch & iZero) | iJump) & ~w_stall;
    assign oPCTarget = inextPCBranch;

    // ------------------------------------------------------------------
    // Access datapath: request capture, wait counter, read buffer
    // ------------------------------------------------------------------
    // The request fields are captured on entry to ACCESS so they stay
    // stable for the whole request regardless of upstream behaviour.
    // NOTE: the read buffer is a plain register, not a RAM array, so it is
    // cheap to reset and a stale value can never leak out after reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wait_cnt  <= 8'd0;
            r_rd_buf    <= 32'd0;
            r_timed_out <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else if (w_start) begin
            r_wait_cnt  <= 8'd0;
            r_timed_out <= 1'b0;
            r_mem_we    <= iMemWrite;     // read+write collapses to a write
            r_mem_addr  <= {iResult[31:2], 2'b00};
            r_mem_wdata <= iB;
        end else if (r_state == S_ACCESS) begin
            if (mem_ack) begin
                r_rd_buf <= mem_rdata;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
                if (w_timeout_hit) begin
                    r_rd_buf    <= 32'd0;
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    // Stalled edges insert a bubble; the data fields keep their value.
    // A misaligned access or a timed-out access retires as a bubble too.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_read_data  <= 32'd0;
            r_result     <= 32'd0;
            r_write_reg  <= 5'd0;
            r_align_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (w_stall) begin
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_align_err  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_reg_write  <= iRegWrite & ~w_misalign &
                            ~((r_state == S_DONE) & r_timed_out);
            r_mem_to_reg <= iMemToReg & ~(iMemRead & iMemWrite) & ~w_misalign;
            r_read_data  <= (r_state == S_DONE) ? r_rd_buf : 32'd0;
            r_result     <= iResult;
            r_write_reg  <= iwriteRegWire;
            r_align_err  <= w_misalign;
            r_timeout    <= (r_state == S_DONE) & r_timed_out;
        end
    end

    assign oRegWrite     = r_reg_write;
    assign oMemToReg     = r_mem_to_reg;
    assign oReadData     = r_read_data;
    assign oResult       = r_result;
    assign owriteRegWire = r_write_reg;
    assign oAlignErr     = r_align_err;
    assign oTimeout      = r_timeout;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl built with TIMEOUT = 3. Each scenario
// drives one EX/MEM instruction, acks the memory a chosen number of cycles
// after the request rises, and compares stall length, request fields and
// MEM/WB outputs against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        iMemRead, iMemWrite, iMemToReg, iRegWrite;
    logic        iBranch, iJump, iZero;
    logic [31:0] iResult, iB, inextPCBranch;
    logic [4:0]  iwriteRegWire;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, oPCSrc;
    logic [31:0] oPCTarget;
    logic        oRegWrite, oMemToReg;
    logic [31:0] oReadData, oResult;
    logic [4:0]  owriteRegWire;
    logic        oAlignErr, oTimeout;

    int n_vec;
    int n_err;

    mem_access_ctrl #(.TIMEOUT(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .iMemRead     (iMemRead),
        .iMemWrite    (iMemWrite),
        .iMemToReg    (iMemToReg),
        .iRegWrite    (iRegWrite),
        .iBranch      (iBranch),
        .iJump        (iJump),
        .iZero        (iZero),
        .iResult      (iResult),
        .iB           (iB),
        .inextPCBranch(inextPCBranch),
        .iwriteRegWire(iwriteRegWire),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .oPCSrc       (oPCSrc),
        .oPCTarget    (oPCTarget),
        .oRegWrite    (oRegWrite),
        .oMemToReg    (oMemToReg),
        .oReadData    (oReadData),
        .oResult      (oResult),
        .owriteRegWire(owriteRegWire),
        .oAlignErr    (oAlignErr),
        .oTimeout     (oTimeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        iMemRead      = 1'b0;
        iMemWrite     = 1'b0;
        iMemToReg     = 1'b0;
        iRegWrite     = 1'b0;
        iBranch       = 1'b0;
        iJump         = 1'b0;
        iZero         = 1'b0;
        iResult       = 32'd0;
        iB            = 32'd0;
        inextPCBranch = 32'd0;
        iwriteRegWire = 5'd0;
        mem_ack       = 1'b0;
    endtask

    // Runs the instruction currently on the inputs until stall drops.
    // ack_at: request-cycle index (0 = first mem_req cycle) that sees
    // mem_ack, or -1 for never. Returns in the first non-stalled cycle,
    // before its edge. Request fields are captured on the first mem_req.
    task automatic run_op(input int ack_at, input logic [31:0] rdata,
                          output int n_stall, output int n_req,
                          output logic cap_we, output logic [31:0] cap_addr,
                          output logic [31:0] cap_wdata,
                          output logic pc_leak);
        int req_idx;
        req_idx   = 0;
        n_stall   = 0;
        n_req     = 0;
        cap_we    = 1'b0;
        cap_addr  = 32'd0;
        cap_wdata = 32'd0;
        pc_leak   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_req) begin
                if (req_idx == 0) begin
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end
                mem_ack   = (req_idx == ack_at);
                mem_rdata = rdata;
                req_idx++;
                n_req++;
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            if (!stall) break;
            if (oPCSrc) pc_leak = 1'b1;
            n_stall++;
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;   // buffer must not follow the bus
    endtask

    int          ns, nr;
    logic        cwe, leak;
    logic [31:0] caddr, cwdata;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        mem_rdata = 32'd0;
        clear_inputs();
        step();
        step();

        // Reset state
        check("rst_stall",    32'(stall),         32'd0);
        check("rst_mem_req",  32'(mem_req),       32'd0);
        check("rst_regwrite", 32'(oRegWrite),     32'd0);
        check("rst_rdata",    oReadData,          32'd0);
        check("rst_result",   oResult,            32'd0);
        check("rst_alignerr", 32'(oAlignErr),     32'd0);
        check("rst_timeout",  32'(oTimeout),      32'd0);
        reset = 1'b1;
        step();

        // Branch taken with no memory op: same-cycle redirect
        iBranch = 1'b1; iZero = 1'b1; inextPCBranch = 32'h0000_4000;
        #1;
        check("br_pcsrc",  32'(oPCSrc), 32'd1);
        check("br_target", oPCTarget,   32'h0000_4000);
        iZero = 1'b0;
        #1;
        check("br_notaken", 32'(oPCSrc), 32'd0);
        iBranch = 1'b0; iJump = 1'b1; inextPCBranch = 32'h0000_8000;
        #1;
        check("jump_pcsrc", 32'(oPCSrc), 32'd1);
        step();
        clear_inputs();

        // Load, ack two cycles after request; branch bits set to show that
        // the redirect is held off while stalled
        iMemRead = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0100; iwriteRegWire = 5'd5;
        iBranch = 1'b1; iZero = 1'b1; inextPCBranch = 32'h0000_1234;
        run_op(2, 32'hCAFE_F00D, ns, nr, cwe, caddr, cwdata, leak);
        check("ld_stall_cycles", 32'(ns),      32'd4);
        check("ld_req_cycles",   32'(nr),      32'd3);
        check("ld_addr",         caddr,        32'h0000_0100);
        check("ld_we",           32'(cwe),     32'd0);
        check("ld_pc_leak",      32'(leak),    32'd0);
        check("ld_done_pcsrc",   32'(oPCSrc),  32'd1);
        step();
        check("ld_rdata",    oReadData,           32'hCAFE_F00D);
        check("ld_regwrite", 32'(oRegWrite),      32'd1);
        check("ld_memtoreg", 32'(oMemToReg),      32'd1);
        check("ld_result",   oResult,             32'h0000_0100);
        check("ld_wreg",     32'(owriteRegWire),  32'd5);

        // Back-to-back load that never gets an ack
        clear_inputs();
        iMemRead = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0400; iwriteRegWire = 5'd7;
        run_op(-1, 32'h1111_1111, ns, nr, cwe, caddr, cwdata, leak);
        check("to_req_cycles",   32'(nr),    32'd3);
        check("to_stall_cycles", 32'(ns),    32'd4);
        check("to_held_rdata",   oReadData,  32'hCAFE_F00D);
        step();
        check("to_pulse",    32'(oTimeout),  32'd1);
        check("to_rdata",    oReadData,      32'd0);
        check("to_regwrite", 32'(oRegWrite), 32'd0);

        // Same load, ack in the last allowed cycle: ack wins
        run_op(2, 32'h0BAD_F00D, ns, nr, cwe, caddr, cwdata, leak);
        check("ack3_req_cycles", 32'(nr),       32'd3);
        check("ack3_timeout",    32'(oTimeout), 32'd0);
        step();
        check("ack3_timeout2", 32'(oTimeout),  32'd0);
        check("ack3_rdata",    oReadData,      32'h0BAD_F00D);
        check("ack3_regwrite", 32'(oRegWrite), 32'd1);

        // Reset applied mid-ACCESS together with an ack
        clear_inputs();
        iMemRead = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0500; iwriteRegWire = 5'd9;
        step();
        check("rs_in_access", 32'(mem_req),   32'd1);
        check("rs_bubble",    32'(oRegWrite), 32'd0);
        check("rs_held_res",  oResult,        32'h0000_0400);
        clear_inputs();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
        step();
        check("rs_mem_req", 32'(mem_req),       32'd0);
        check("rs_stall",   32'(stall),         32'd0);
        check("rs_result",  oResult,            32'd0);
        check("rs_rdata",   oReadData,          32'd0);
        check("rs_wreg",    32'(owriteRegWire), 32'd0);
        check("rs_addr",    mem_addr,           32'd0);
        reset = 1'b1;
        step();
        check("rs_ack_ignored", 32'(mem_req), 32'd0);
        check("rs_rdata2",      oReadData,    32'd0);
        mem_ack = 1'b0;

        // Store, immediate ack, register write requested
        iMemWrite = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0204; iB = 32'h1234_5678; iwriteRegWire = 5'd3;
        run_op(0, 32'h0, ns, nr, cwe, caddr, cwdata, leak);
        check("st_stall_cycles", 32'(ns),  32'd2);
        check("st_we",           32'(cwe), 32'd1);
        check("st_addr",         caddr,    32'h0000_0204);
        check("st_wdata",        cwdata,   32'h1234_5678);
        step();
        check("st_regwrite", 32'(oRegWrite), 32'd1);

        // Store without register write
        iRegWrite = 1'b0; iResult = 32'h0000_0208;
        run_op(0, 32'h0, ns, nr, cwe, caddr, cwdata, leak);
        step();
        check("st_noregwrite", 32'(oRegWrite), 32'd0);

        // Read and write together: performs a write, MemToReg forced off
        clear_inputs();
        iMemRead = 1'b1; iMemWrite = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0300; iB = 32'hA5A5_0001;
        run_op(1, 32'h7777_7777, ns, nr, cwe, caddr, cwdata, leak);
        check("rw_stall_cycles", 32'(ns),  32'd3);
        check("rw_we",           32'(cwe), 32'd1);
        step();
        check("rw_memtoreg", 32'(oMemToReg), 32'd0);
        check("rw_regwrite", 32'(oRegWrite), 32'd1);

        // Misaligned load: no request, no stall, bubble plus error pulse
        clear_inputs();
        iMemRead = 1'b1; iMemToReg = 1'b1; iRegWrite = 1'b1;
        iResult = 32'h0000_0102;
        #1;
        check("mis_mem_req", 32'(mem_req), 32'd0);
        check("mis_stall",   32'(stall),   32'd0);
        step();
        check("mis_alignerr", 32'(oAlignErr), 32'd1);
        check("mis_regwrite", 32'(oRegWrite), 32'd0);
        check("mis_mem_req2", 32'(mem_req),   32'd0);
        clear_inputs();
        step();
        check("mis_pulse_end", 32'(oAlignErr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
